seq_check_sched: RTL and testbench

SEQ_CHECK_SCHED -- requirements
Module: seq_check_sched

---
 rtl/seq_check_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/seq_check_sched.sv | 144 ++++++++++++++
 tb/tb_seq_check_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_check_pkg.sv
// Shared defaults and FSM states for the
// multi-channel serial pattern checker.
package seq_check_pkg;

  localparam int NCH_DEF    = 4;
  localparam int MAXLEN_DEF = 8;
  localparam int CNTW_DEF   = 16;

  typedef enum logic [1:0] {
    UNCONF = 2'd0,
    RUN    = 2'd1,
    FLUSH  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter; search starts
// one past the last granted requester.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  logic [W-1:0] last;
  logic [W-1:0] nxt;
  logic [W-1:0] j;
  logic         found;

  always_comb begin
    grant = '0;
    nxt   = last;
    found = 1'b0;
    j     = '0;
    for (int i = 1; i <= N; i++) begin
      j = W'((int'(last) + i) % N);
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        nxt      = j;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last <= W'(N - 1);
    else if (advance && found)
      last <= nxt;
  end

endmodule

// File: rtl/seq_check_sched.sv
// Serial pattern detector time-shared across
// channels with per-channel match counters.
module seq_check_sched
  import seq_check_pkg::*;
#(
  parameter int NCH    = NCH_DEF,
  parameter int MAXLEN = MAXLEN_DEF,
  parameter int CNTW   = CNTW_DEF,
  parameter int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    ch_valid,
  input  logic [NCH-1:0]    ch_bit,
  output logic [NCH-1:0]    ch_ready,
  input  logic              cfg_we,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [3:0]        cfg_len,
  output logic              match_valid,
  output logic [CHW-1:0]    match_ch,
  input  logic [CHW-1:0]    cnt_sel,
  input  logic              cnt_clr,
  output logic [CNTW-1:0]   cnt_value
);

  localparam int FW = $clog2(MAXLEN + 1);

  state_t            state;
  logic [MAXLEN-1:0] pattern;
  logic [3:0]        len;
  logic              cfg_ok;
  logic [NCH-1:0]    grant;
  logic              acc;

  logic [MAXLEN-1:0] hist [NCH];
  logic [FW-1:0]     fill [NCH];
  logic [CNTW-1:0]   cnt  [NCH];

  logic [CHW-1:0]    sel;
  logic [MAXLEN-1:0] nh;
  logic [FW-1:0]     nf;
  logic [MAXLEN-1:0] mask;
  logic              hit;

  assign cfg_ok = cfg_we && (cfg_len != 4'd0)
               && (int'(cfg_len) <= MAXLEN);

  // A legal reconfigure takes priority over data.
  assign ch_ready = (state == RUN && !cfg_ok)
                  ? grant : '0;
  assign acc = |ch_ready;

  rr_arbiter #(
    .N (NCH),
    .W (CHW)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (ch_valid),
    .advance (acc),
    .grant   (grant)
  );

  always_comb begin
    sel = '0;
    for (int c = 0; c < NCH; c++)
      if (grant[c]) sel = CHW'(c);
    nh = (hist[sel] << 1)
       | MAXLEN'(ch_bit[sel]);
    nf = (int'(fill[sel]) >= MAXLEN)
       ? fill[sel] : fill[sel] + 1'b1;
    mask = '0;
    for (int i = 0; i < MAXLEN; i++)
      mask[i] = (i < int'(len));
    hit = acc
       && (int'(nf) >= int'(len))
       && (((nh ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= UNCONF;
      pattern     <= '0;
      len         <= '0;
      match_valid <= 1'b0;
      match_ch    <= '0;
    end else begin
      match_valid <= 1'b0;
      match_ch    <= '0;
      if (cfg_ok) begin
        pattern <= cfg_pattern;
        len     <= cfg_len;
        state   <= FLUSH;
      end else begin
        case (state)
          UNCONF: state <= UNCONF;
          FLUSH:  state <= RUN;
          RUN: begin
            if (hit) begin
              match_valid <= 1'b1;
              match_ch    <= sel;
            end
          end
          default: state <= UNCONF;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        hist[c] <= '0;
        fill[c] <= '0;
      end
    end else if (state == FLUSH) begin
      for (int c = 0; c < NCH; c++) begin
        hist[c] <= '0;
        fill[c] <= '0;
      end
    end else if (acc) begin
      hist[sel] <= nh;
      fill[sel] <= nf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++)
        cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (cnt_clr && cnt_sel == CHW'(c))
          cnt[c] <= '0;
        else if (hit && sel == CHW'(c)
                 && cnt[c] != '1)
          cnt[c] <= cnt[c] + 1'b1;
      end
    end
  end

  assign cnt_value = cnt[cnt_sel];

endmodule

// File: tb/tb_seq_check_sched.sv
// Directed bench for seq_check_sched; a narrow
// counter instance covers saturation.
module tb_seq_check_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  ch_valid, ch_bit, ch_ready;
  logic        cfg_we;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        match_valid;
  logic [1:0]  match_ch, cnt_sel;
  logic        cnt_clr;
  logic [15:0] cnt_value;

  logic [3:0]  s_valid, s_bit, s_ready;
  logic        s_cfg_we;
  logic [7:0]  s_cfg_pattern;
  logic [3:0]  s_cfg_len;
  logic        s_mv;
  logic [1:0]  s_mch, s_sel;
  logic        s_clr;
  logic [3:0]  s_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  seq_check_sched dut (
    .clk         (clk),
    .rst         (rst),
    .ch_valid    (ch_valid),
    .ch_bit      (ch_bit),
    .ch_ready    (ch_ready),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .match_valid (match_valid),
    .match_ch    (match_ch),
    .cnt_sel     (cnt_sel),
    .cnt_clr     (cnt_clr),
    .cnt_value   (cnt_value)
  );

  seq_check_sched #(.CNTW(4)) dut_s (
    .clk         (clk),
    .rst         (rst),
    .ch_valid    (s_valid),
    .ch_bit      (s_bit),
    .ch_ready    (s_ready),
    .cfg_we      (s_cfg_we),
    .cfg_pattern (s_cfg_pattern),
    .cfg_len     (s_cfg_len),
    .match_valid (s_mv),
    .match_ch    (s_mch),
    .cnt_sel     (s_sel),
    .cnt_clr     (s_clr),
    .cnt_value   (s_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch,
                      input logic b);
    ch_valid     = 4'(1 << ch);
    ch_bit       = '0;
    ch_bit[ch]   = b;
    #0;
    chk("rdy", 32'(ch_ready), 32'(1 << ch));
    tick();
    ch_valid = '0;
    ch_bit   = '0;
  endtask

  task automatic cfg(input logic [7:0] pat,
                     input logic [3:0] l);
    cfg_pattern = pat;
    cfg_len     = l;
    cfg_we      = 1'b1;
    tick();
    cfg_we   = 1'b0;
    ch_valid = 4'hF;
    #1;
    chk("flush_rdy", 32'(ch_ready), 0);
    chk("flush_mv", 32'(match_valid), 0);
    ch_valid = '0;
    tick();
  endtask

  logic [3:0] exp_g [6];

  initial begin
    exp_g = '{4'b0001, 4'b0010, 4'b1000,
              4'b0001, 4'b0010, 4'b1000};
    rst = 1'b1;
    ch_valid = '0; ch_bit = '0;
    cfg_we = 1'b0; cfg_pattern = '0;
    cfg_len = '0; cnt_sel = '0;
    cnt_clr = 1'b0;
    s_valid = '0; s_bit = '0;
    s_cfg_we = 1'b0; s_cfg_pattern = '0;
    s_cfg_len = '0; s_sel = '0;
    s_clr = 1'b0;
    #2;
    chk("rst_rdy", 32'(ch_ready), 0);
    chk("rst_mv", 32'(match_valid), 0);
    chk("rst_mch", 32'(match_ch), 0);
    chk("rst_cnt", 32'(cnt_value), 0);
    #10 rst = 1'b0;
    tick();

    // unconfigured: no grants, no matches
    ch_valid = 4'hF;
    repeat (3) begin
      #1;
      chk("uncf_rdy", 32'(ch_ready), 0);
      chk("uncf_mv", 32'(match_valid), 0);
      tick();
    end
    ch_valid = '0;

    cfg(8'b110, 4'd3);

    ch_valid = 4'b1011;
    ch_bit   = '0;
    for (int i = 0; i < 6; i++) begin
      #0;
      chk("rr", 32'(ch_ready), 32'(exp_g[i]));
      tick();
    end
    ch_valid = '0;
    tick();
    tick();
    ch_valid = 4'b0110;
    #1;
    chk("rr_hold", 32'(ch_ready), 32'b0010);
    ch_valid = '0;

    cfg(8'b110, 4'd3);
    cnt_sel = 2'd0;
    push(0, 1'b1);
    chk("m36_a", 32'(match_valid), 0);
    push(0, 1'b1);
    chk("m36_b", 32'(match_valid), 0);
    push(0, 1'b0);
    chk("m36_mv", 32'(match_valid), 1);
    chk("m36_ch", 32'(match_ch), 0);
    chk("m36_cnt", 32'(cnt_value), 1);
    tick();
    chk("m36_pulse", 32'(match_valid), 0);

    cfg(8'b11, 4'd2);
    push(2, 1'b1);
    chk("ov_1", 32'(match_valid), 0);
    push(2, 1'b1);
    chk("ov_2", 32'(match_valid), 1);
    chk("ov_2ch", 32'(match_ch), 2);
    cfg_pattern = '0;
    cfg_len     = 4'd9;
    cfg_we      = 1'b1;
    tick();
    cfg_we = 1'b0;
    push(2, 1'b1);
    chk("ov_3", 32'(match_valid), 1);
    push(2, 1'b1);
    chk("ov_4", 32'(match_valid), 1);
    chk("ov_4ch", 32'(match_ch), 2);
    cnt_sel = 2'd2;
    #1;
    chk("ov_cnt", 32'(cnt_value), 3);
    cnt_sel = 2'd0;
    #1;
    chk("cnt_keep", 32'(cnt_value), 1);

    cnt_sel = 2'd2;
    cnt_clr = 1'b1;
    push(2, 1'b1);
    cnt_clr = 1'b0;
    chk("clr_mv", 32'(match_valid), 1);
    #1;
    chk("clr_win", 32'(cnt_value), 0);

    cfg(8'b110, 4'd3);
    push(1, 1'b1);
    push(1, 1'b1);
    cfg(8'b110, 4'd3);
    push(1, 1'b0);
    chk("rcfg_mv", 32'(match_valid), 0);
    cnt_sel = 2'd1;
    #1;
    chk("rcfg_cnt", 32'(cnt_value), 0);

    s_cfg_pattern = 8'b1;
    s_cfg_len     = 4'd1;
    s_cfg_we      = 1'b1;
    tick();
    s_cfg_we = 1'b0;
    tick();
    s_valid = 4'b0001;
    s_bit   = 4'b0001;
    repeat (15) tick();
    chk("sat_fill", 32'(s_cnt), 32'hF);
    chk("sat_mv", 32'(s_mv), 1);
    tick();
    chk("sat_hold", 32'(s_cnt), 32'hF);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    chk("sat_clr", 32'(s_cnt), 0);
    s_valid = '0;

    push(1, 1'b1);
    push(1, 1'b1);
    push(1, 1'b0);
    chk("pre_rst_mv", 32'(match_valid), 1);
    rst = 1'b1;
    ch_valid = 4'b0001;
    #1;
    chk("arst_mv", 32'(match_valid), 0);
    chk("arst_mch", 32'(match_ch), 0);
    chk("arst_rdy", 32'(ch_ready), 0);
    chk("arst_cnt", 32'(cnt_value), 0);
    ch_valid = '0;

    $display("%0d/%0d checks passed",
             n_pass, n_chk);
    $finish;
  end

endmodule
